h_gate_pipe_param: RTL and testbench

- Parametrised, multi-lane, flow-controlled Hadamard butterfly for the reduced-QFT pipeline.
- Per lane, computes new_alpha = (alpha+beta)·C and new_beta = (alpha−beta)·C, where C ≈ 1/sqrt2 in fixed point.
- Successor to the fixed S3.4 single-lane Hadamard stage. Adds:
  - width, fraction, coefficient and lane-count parameters
  - valid/ready handshake with stall
  - selectable rounding
  - output saturation
  - configurable latency

---
 rtl/h_gate_pipe_param_pkg.sv | 19 +
 rtl/h_gate_pipe_param_if.sv | 43 ++++
 rtl/h_gate_pipe_param_lane.sv | 87 ++++++++
 rtl/h_gate_pipe_param.sv | 117 +++++++++++
 tb/tb_h_gate_pipe_param.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/h_gate_pipe_param_pkg.sv
// Shared constants for the parametrised Hadamard butterfly pipeline.
// Default sample format S3.4 with a Q4 1/sqrt2 coefficient.
package h_gate_pipe_param_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_FRAC  = 4;
  localparam int DEF_COEF  = 11;
  localparam int SAT_W     = 16;
  localparam int NCOMP     = 4;

  // Per-lane datapath component slots
  typedef enum int {
    C_SR = 0,
    C_SI = 1,
    C_DR = 2,
    C_DI = 3
  } comp_e;

endpackage

// File: rtl/h_gate_pipe_param_if.sv
// Handshake and packed lane bundle for the Hadamard pipeline.
// master drives beats in and accepts results; slave is the block.
interface h_gate_pipe_param_if
  import h_gate_pipe_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = 1
);
  localparam int DW = LANES * WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    alpha_r;
  logic [DW-1:0]    alpha_i;
  logic [DW-1:0]    beta_r;
  logic [DW-1:0]    beta_i;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    new_alpha_r;
  logic [DW-1:0]    new_alpha_i;
  logic [DW-1:0]    new_beta_r;
  logic [DW-1:0]    new_beta_i;
  logic [SAT_W-1:0] sat_count;

  modport master (
    output in_valid, alpha_r, alpha_i,
    output beta_r, beta_i, out_ready,
    input  in_ready, out_valid,
    input  new_alpha_r, new_alpha_i,
    input  new_beta_r, new_beta_i,
    input  sat_count
  );

  modport slave (
    input  in_valid, alpha_r, alpha_i,
    input  beta_r, beta_i, out_ready,
    output in_ready, out_valid,
    output new_alpha_r, new_alpha_i,
    output new_beta_r, new_beta_i,
    output sat_count
  );

endinterface

// File: rtl/h_gate_pipe_param_lane.sv
// Single-lane butterfly datapath: sum/diff, coefficient multiply,
// round/shift/saturate. Data only; the top owns the valid chain.
module h_butterfly_lane
  import h_gate_pipe_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int COEF  = DEF_COEF,
  parameter int ROUND = 1
) (
  input  logic                    clk,
  input  logic                    rst_s,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] ar,
  input  logic signed [WIDTH-1:0] ai,
  input  logic signed [WIDTH-1:0] br,
  input  logic signed [WIDTH-1:0] bi,
  output logic signed [WIDTH-1:0] nar,
  output logic signed [WIDTH-1:0] nai,
  output logic signed [WIDTH-1:0] nbr,
  output logic signed [WIDTH-1:0] nbi,
  output logic                    clip
);

  localparam int SW   = WIDTH + 1;
  localparam int PW   = WIDTH + FRAC + 2;
  localparam int QW   = WIDTH + 2;
  localparam int RNDI =
    (ROUND != 0) ? (1 << (FRAC - 1)) : 0;

  localparam logic [FRAC:0] CU = COEF[FRAC:0];
  localparam logic signed [PW-1:0] KC = PW'(CU);
  localparam logic signed [PW-1:0] RADD = PW'(RNDI);
  localparam logic signed [QW-1:0] MAXV =
    QW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [QW-1:0] MINV =
    QW'(-(1 << (WIDTH - 1)));

  logic signed [SW-1:0]    s2   [NCOMP];
  logic signed [PW-1:0]    s3   [NCOMP];
  logic signed [WIDTH-1:0] s4   [NCOMP];
  logic signed [QW-1:0]    shf  [NCOMP];
  logic signed [WIDTH-1:0] satv [NCOMP];

  // Product never exceeds QW bits after the shift, so clip
  // detection on shf is exact.
  always_comb begin
    clip = 1'b0;
    for (int c = 0; c < NCOMP; c++) begin
      shf[c] = QW'((s3[c] + RADD) >>> FRAC);
      if (shf[c] > MAXV) begin
        satv[c] = MAXV[WIDTH-1:0];
        clip    = 1'b1;
      end else if (shf[c] < MINV) begin
        satv[c] = MINV[WIDTH-1:0];
        clip    = 1'b1;
      end else begin
        satv[c] = shf[c][WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_s) begin
      for (int c = 0; c < NCOMP; c++) begin
        s2[c] <= '0;
        s3[c] <= '0;
        s4[c] <= '0;
      end
    end else if (en) begin
      s2[C_SR] <= SW'(ar) + SW'(br);
      s2[C_SI] <= SW'(ai) + SW'(bi);
      s2[C_DR] <= SW'(ar) - SW'(br);
      s2[C_DI] <= SW'(ai) - SW'(bi);
      for (int c = 0; c < NCOMP; c++) begin
        s3[c] <= PW'(s2[c]) * KC;
        s4[c] <= satv[c];
      end
    end
  end

  assign nar = s4[C_SR];
  assign nai = s4[C_SI];
  assign nbr = s4[C_DR];
  assign nbi = s4[C_DI];

endmodule

// File: rtl/h_gate_pipe_param.sv
// Multi-lane flow-controlled Hadamard butterfly, latency 4+EXTRA_STAGES.
// Optional saturation counter enabled by H_GATE_SAT_CNT_EN.
module h_gate_pipe_param
  import h_gate_pipe_param_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int FRAC         = DEF_FRAC,
  parameter int COEF         = DEF_COEF,
  parameter int LANES        = 1,
  parameter int ROUND        = 1,
  parameter int EXTRA_STAGES = 6
) (
  input logic clk,
  input logic rst_s,
  h_gate_pipe_param_if.slave io
);

  localparam int DW = LANES * WIDTH;
  localparam int BW = 4 * DW;
  localparam int L  = 4 + EXTRA_STAGES;

  logic             stall;
  logic             en;
  logic [L:1]       vld;
  logic [DW-1:0]    s1_ar, s1_ai, s1_br, s1_bi;
  logic [DW-1:0]    s4_ar, s4_ai, s4_br, s4_bi;
  logic [LANES-1:0] clip;
  logic [BW-1:0]    s4_bus;
  logic [BW-1:0]    out_bus;

  // Global stall: the whole pipe freezes while the head waits
  assign stall        = vld[L] & ~io.out_ready;
  assign en           = ~stall;
  assign io.in_ready  = en;
  assign io.out_valid = vld[L];

  always_ff @(posedge clk) begin
    if (rst_s) begin
      vld   <= '0;
      s1_ar <= '0;
      s1_ai <= '0;
      s1_br <= '0;
      s1_bi <= '0;
    end else if (en) begin
      vld   <= {vld[L-1:1], io.in_valid};
      s1_ar <= io.alpha_r;
      s1_ai <= io.alpha_i;
      s1_br <= io.beta_r;
      s1_bi <= io.beta_i;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    h_butterfly_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .COEF  (COEF),
      .ROUND (ROUND)
    ) u_lane (
      .clk   (clk),
      .rst_s (rst_s),
      .en    (en),
      .ar    (s1_ar[k*WIDTH +: WIDTH]),
      .ai    (s1_ai[k*WIDTH +: WIDTH]),
      .br    (s1_br[k*WIDTH +: WIDTH]),
      .bi    (s1_bi[k*WIDTH +: WIDTH]),
      .nar   (s4_ar[k*WIDTH +: WIDTH]),
      .nai   (s4_ai[k*WIDTH +: WIDTH]),
      .nbr   (s4_br[k*WIDTH +: WIDTH]),
      .nbi   (s4_bi[k*WIDTH +: WIDTH]),
      .clip  (clip[k])
    );
  end

  assign s4_bus = {s4_bi, s4_br, s4_ai, s4_ar};

  if (EXTRA_STAGES == 0) begin : g_nodly
    assign out_bus = s4_bus;
  end else begin : g_dly
    logic [BW-1:0] dly [EXTRA_STAGES];
    always_ff @(posedge clk) begin
      if (rst_s) begin
        for (int i = 0; i < EXTRA_STAGES; i++)
          dly[i] <= '0;
      end else if (en) begin
        dly[0] <= s4_bus;
        for (int i = 1; i < EXTRA_STAGES; i++)
          dly[i] <= dly[i-1];
      end
    end
    assign out_bus = dly[EXTRA_STAGES-1];
  end

  assign io.new_alpha_r = out_bus[0*DW +: DW];
  assign io.new_alpha_i = out_bus[1*DW +: DW];
  assign io.new_beta_r  = out_bus[2*DW +: DW];
  assign io.new_beta_i  = out_bus[3*DW +: DW];

`ifdef H_GATE_SAT_CNT_EN
  logic [SAT_W-1:0] sat_q;

  // clip is combinational off S3, counted as the beat enters S4
  always_ff @(posedge clk) begin
    if (rst_s)
      sat_q <= '0;
    else if (en && vld[3] && (|clip) && (sat_q != '1))
      sat_q <= sat_q + 1'b1;
  end

  assign io.sat_count = sat_q;
`else
  logic unused_clip;
  assign unused_clip  = ^clip;
  assign io.sat_count = '0;
`endif

endmodule

// File: tb/tb_h_gate_pipe_param.sv
// Bench for h_gate_pipe_param: two configurations against a
// behavioural butterfly model with a scoreboard per instance.
module tb_h_gate_pipe_param;

  localparam int LA = 10;
  localparam int LB = 4;

  typedef struct {
    logic [31:0] ar, ai, br, bi;
    int          cyc;
    int          snap;
  } exp_t;

  logic clk;
  logic rst_s;

  h_gate_pipe_param_if #(.WIDTH(8), .LANES(2)) ia ();
  h_gate_pipe_param_if #(.WIDTH(8), .LANES(4)) ib ();

  h_gate_pipe_param #(.LANES(2)) u_a (
    .clk   (clk),
    .rst_s (rst_s),
    .io    (ia)
  );

  h_gate_pipe_param #(
    .LANES(4), .ROUND(0), .EXTRA_STAGES(0)
  ) u_b (
    .clk   (clk),
    .rst_s (rst_s),
    .io    (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk, n_fail;
  int   cyc, st_a, st_b;
  int   sat_a, sat_b;
  int   a_pops, b_pops;
  bit   acc_a, acc_b, a_hold, b_hold;
  exp_t qa[$], qb[$];
  exp_t a_last, b_last;
  logic [31:0] xa_ar, xa_ai, xa_br, xa_bi;
  logic [31:0] xb_ar, xb_ai, xb_br, xb_bi;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Hadamard half: (a +/- b) * 11/16 with optional half-up rounding
  function automatic logic [7:0] hb1(
    input int a, input int b,
    input bit sub, input bit rnd,
    output bit cl);
    int s, p, q;
    s = sub ? a - b : a + b;
    p = s * 11;
    if (rnd) p = p + 8;
    q = p >>> 4;
    cl = 1'b0;
    if (q > 127) begin q = 127; cl = 1'b1; end
    if (q < -128) begin q = -128; cl = 1'b1; end
    return 8'(q);
  endfunction

  function automatic exp_t model(
    input logic [31:0] ar, ai, br, bi,
    input int lanes, input bit rnd,
    output bit anyc);
    exp_t e;
    int xr, xi, yr, yi;
    bit c;
    e = '{ar: '0, ai: '0, br: '0, bi: '0,
          cyc: 0, snap: 0};
    anyc = 1'b0;
    for (int k = 0; k < lanes; k++) begin
      xr = int'($signed(ar[k*8 +: 8]));
      xi = int'($signed(ai[k*8 +: 8]));
      yr = int'($signed(br[k*8 +: 8]));
      yi = int'($signed(bi[k*8 +: 8]));
      e.ar[k*8 +: 8] = hb1(xr, yr, 0, rnd, c);
      anyc |= c;
      e.ai[k*8 +: 8] = hb1(xi, yi, 0, rnd, c);
      anyc |= c;
      e.br[k*8 +: 8] = hb1(xr, yr, 1, rnd, c);
      anyc |= c;
      e.bi[k*8 +: 8] = hb1(xi, yi, 1, rnd, c);
      anyc |= c;
    end
    return e;
  endfunction

  function automatic logic [31:0] sat_exp(input int n);
`ifdef H_GATE_SAT_CNT_EN
    return (n > 65535) ? 32'd65535 : 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic cmp(input string t, input exp_t o,
                     input exp_t e, input int lat,
                     input int elat);
    chk({t, "_ar"}, o.ar, e.ar);
    chk({t, "_ai"}, o.ai, e.ai);
    chk({t, "_br"}, o.br, e.br);
    chk({t, "_bi"}, o.bi, e.bi);
    chk({t, "_lat"}, lat, elat);
  endtask

  task automatic rand_a();
    xa_ar = $urandom; xa_ai = $urandom;
    xa_br = $urandom; xa_bi = $urandom;
  endtask

  task automatic rand_b();
    xb_ar = $urandom; xb_ai = $urandom;
    xb_br = $urandom; xb_bi = $urandom;
  endtask

  task automatic step(input bit va, input bit vb,
                      input bit rdy);
    exp_t e, o;
    bit   c;
    ia.in_valid = va;    ib.in_valid = vb;
    ia.alpha_r = xa_ar[15:0]; ia.alpha_i = xa_ai[15:0];
    ia.beta_r  = xa_br[15:0]; ia.beta_i  = xa_bi[15:0];
    ib.alpha_r = xb_ar;  ib.alpha_i = xb_ai;
    ib.beta_r  = xb_br;  ib.beta_i  = xb_bi;
    ia.out_ready = rdy;  ib.out_ready = rdy;
    #1;
    chk("a_in_ready", ia.in_ready,
        !(ia.out_valid && !rdy));
    chk("b_in_ready", ib.in_ready,
        !(ib.out_valid && !rdy));
    acc_a = va && ia.in_ready;
    acc_b = vb && ib.in_ready;
    if (acc_a) begin
      e = model(xa_ar, xa_ai, xa_br, xa_bi, 2, 1, c);
      e.cyc = cyc; e.snap = st_a;
      qa.push_back(e);
      if (c) sat_a++;
    end
    if (acc_b) begin
      e = model(xb_ar, xb_ai, xb_br, xb_bi, 4, 0, c);
      e.cyc = cyc; e.snap = st_b;
      qb.push_back(e);
      if (c) sat_b++;
    end
    o.ar = 32'(ia.new_alpha_r); o.ai = 32'(ia.new_alpha_i);
    o.br = 32'(ia.new_beta_r);  o.bi = 32'(ia.new_beta_i);
    if (a_hold) chk("a_hold_valid", ia.out_valid, 1);
    a_hold = ia.out_valid && !rdy;
    if (ia.out_valid) begin
      if (qa.size() == 0) chk("a_extra_beat", 1, 0);
      else if (!rdy) begin
        cmp("a_frozen", o, qa[0], 0, 0);
        st_a++;
      end else begin
        e = qa.pop_front();
        cmp("a", o, e, cyc - e.cyc, LA + st_a - e.snap);
        a_last = o; a_pops++;
      end
    end
    o.ar = ib.new_alpha_r; o.ai = ib.new_alpha_i;
    o.br = ib.new_beta_r;  o.bi = ib.new_beta_i;
    if (b_hold) chk("b_hold_valid", ib.out_valid, 1);
    b_hold = ib.out_valid && !rdy;
    if (ib.out_valid) begin
      if (qb.size() == 0) chk("b_extra_beat", 1, 0);
      else if (!rdy) begin
        cmp("b_frozen", o, qb[0], 0, 0);
        st_b++;
      end else begin
        e = qb.pop_front();
        cmp("b", o, e, cyc - e.cyc, LB + st_b - e.snap);
        b_last = o; b_pops++;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() + qb.size()) != 0 && n < 60) begin
      step(0, 0, 1);
      n++;
    end
    chk("drain_left", qa.size() + qb.size(), 0);
  endtask

  task automatic do_reset();
    rst_s = 1'b1;
    ia.in_valid = 1'b0; ib.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_s = 1'b0;
    qa.delete(); qb.delete();
    sat_a = 0; sat_b = 0;
    a_hold = 0; b_hold = 0;
    chk("rst_a_valid", ia.out_valid, 0);
    chk("rst_b_valid", ib.out_valid, 0);
    chk("rst_a_nar", ia.new_alpha_r, 0);
    chk("rst_b_nbi", ib.new_beta_i, 0);
    chk("rst_a_sat", ia.sat_count, 0);
  endtask

  task automatic one_beat(input logic [7:0] a,
                          input logic [7:0] b);
    xa_ar = 0; xa_ai = 0; xa_br = 0; xa_bi = 0;
    xb_ar = 0; xb_ai = 0; xb_br = 0; xb_bi = 0;
    xa_ar[7:0] = a; xa_br[7:0] = b;
    xb_ar[7:0] = a; xb_br[7:0] = b;
    step(1, 1, 1);
  endtask

  initial begin
    int n, p0, sa, sb, t;
    n_chk = 0; n_fail = 0; cyc = 0;
    st_a = 0; st_b = 0; a_pops = 0; b_pops = 0;
    rst_s = 1'b1;
    ia.in_valid = 0; ib.in_valid = 0;
    ia.out_ready = 1; ib.out_ready = 1;
    rand_a(); rand_b();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single beat: latency 10 and a one-cycle valid pulse
    one_beat(8'd16, 8'd16);
    n = 0; p0 = a_pops;
    while (a_pops == p0 && n < 30) begin
      step(0, 0, 1);
      n++;
    end
    chk("lat_16", n, LA);
    chk("nar_16", a_last.ar[7:0], 8'd22);
    chk("nbr_16", a_last.br[7:0], 8'd0);
    chk("pulse_once", ia.out_valid, 0);
    drain();

    // Rounding: A rounds half-up, B truncates
    one_beat(8'd1, 8'd0);
    drain();
    chk("rnd_a_nar", a_last.ar[7:0], 8'd1);
    chk("rnd_a_nbr", a_last.br[7:0], 8'd1);
    chk("trn_b_nar", b_last.ar[7:0], 8'd0);
    chk("trn_b_nbr", b_last.br[7:0], 8'd0);
    one_beat(8'hF0, 8'd0);
    drain();
    chk("neg_a_nar", a_last.ar[7:0], 8'hF5);
    chk("neg_b_nar", b_last.ar[7:0], 8'hF5);

    // Saturation corners
    one_beat(8'd127, 8'd127);
    one_beat(8'h80, 8'h80);
    one_beat(8'd127, 8'h80);
    drain();
    chk("sat_nbr", a_last.br[7:0], 8'd127);
    chk("sat3_a", ia.sat_count, sat_exp(3));
    chk("sat3_b", ib.sat_count, sat_exp(3));

    // 20-beat stream with a 5-cycle back-pressure window
    sa = 0; sb = 0; t = 0; p0 = a_pops;
    rand_a(); rand_b();
    while ((sa < 20 || sb < 20) && t < 200) begin
      step(sa < 20, sb < 20, !(t >= 12 && t < 17));
      if (acc_a) begin sa++; rand_a(); end
      if (acc_b) begin sb++; rand_b(); end
      t++;
    end
    chk("stream_sent_a", sa, 20);
    drain();
    chk("stream_out_a", a_pops - p0, 20);
    chk("stream_sat_a", ia.sat_count, sat_exp(sat_a));
    chk("stream_sat_b", ib.sat_count, sat_exp(sat_b));

    // Reset with beats in flight: nothing stale may emerge
    for (int i = 0; i < 6; i++) begin
      rand_a(); rand_b();
      step(1, 1, 1);
    end
    do_reset();
    p0 = a_pops + b_pops;
    repeat (15) step(0, 0, 1);
    chk("post_rst_pops", a_pops + b_pops - p0, 0);

    // Random traffic and back-pressure
    rand_a(); rand_b();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 1) != 0,
           $urandom_range(0, 3) != 0);
      if (acc_a) rand_a();
      if (acc_b) rand_b();
    end
    drain();
    chk("rand_sat_a", ia.sat_count, sat_exp(sat_a));
    chk("rand_sat_b", ib.sat_count, sat_exp(sat_b));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
